arbiter_encoder: RTL
====================

ARBITER_ENCODER -- requirements
Module: arbiter_encoder

Interface
REQ-001 SHALL provide parameter: TIMEOUT, default 15, max cycles a grant is held without i_done (legal range 2..255).
REQ-002 SHALL provide port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: i_request  input  8  per-row access requests, bit n = row n.
REQ-005 SHALL provide port: i_done  input  1  current granted access complete; release grant.
REQ-006 SHALL provide port: o_k_address  output  3  binary index of granted row, directly drives the 3-bit row-select decoder address.
REQ-007 SHALL provide port: o_valid  output  1  grant active, directly drives the row-select decoder valid.
REQ-008 SHALL provide port: o_grant  output  8  one-hot of o_k_address gated by o_valid.
REQ-009 SHALL provide port: o_timeout  output  1  one-cycle pulse, grant released by timeout.

Function
REQ-010 SHALL register all outputs; no combinational path from any input to any output.
REQ-011 SHALL implement FSM states IDLE, GRANT, RELEASE.
REQ-012 SHALL hold a 3-bit round-robin pointer ptr; search order ptr, ptr+1, ... ptr+7, mod 8.
REQ-013 IDLE: if i_request != 0 at an edge, SHALL enter GRANT at that edge with o_k_address = first set bit in search order, o_valid = 1 (latency 1 cycle).
REQ-014 IDLE: if i_request == 0, SHALL remain IDLE with o_valid = 0; i_done ignored.
REQ-015 GRANT: o_k_address SHALL stay constant; i_request changes (including drop of granted bit) SHALL be ignored.
REQ-016 GRANT: 8-bit timer SHALL clear on entering GRANT and increment every GRANT cycle.
REQ-017 GRANT: i_done = 1 at an edge SHALL move to RELEASE, o_valid = 0 after that edge.
REQ-018 GRANT: i_done = 0 with timer == TIMEOUT-1 SHALL move to RELEASE, o_valid = 0 and o_timeout = 1 for exactly one cycle; o_valid thus high exactly TIMEOUT cycles.
REQ-019 i_done and timeout in same cycle: i_done SHALL take precedence, o_timeout stays 0.
REQ-020 On leaving GRANT, ptr SHALL be set to (granted index + 1) mod 8 (wraps 7 -> 0).
REQ-021 RELEASE: SHALL last exactly one cycle with o_valid = 0; then arbitrate as IDLE (GRANT if any request, else IDLE); minimum gap between grants one cycle.
REQ-022 o_grant SHALL equal 1 << o_k_address when o_valid = 1, else 8'h00; never more than one bit set.
REQ-023 o_k_address SHALL retain last granted value while o_valid = 0 (except after reset).

Reset
REQ-024 i_rst_n low SHALL immediately, without clock edge, force state IDLE, ptr 0, timer 0, o_k_address 3'd0, o_valid 0, o_grant 8'h00, o_timeout 0.
REQ-025 Reset mid-grant SHALL abort the grant; no o_timeout pulse generated.
REQ-026 First arbitration after reset deassertion SHALL occur on the first rising edge with i_rst_n high.

Verification
REQ-027 Reset: i_rst_n low, i_request = 8'hFF -> all outputs 0; release -> after first edge o_valid = 1, o_k_address = 0, o_grant = 8'h01.
REQ-028 Round robin: i_request = 8'hFF, i_done pulsed second cycle of each grant -> addresses 0,1,2,3,4,5,6,7,0 with one o_valid-low cycle between each.
REQ-029 Wrap search: after grant of 5 completes, i_request = 8'h21 -> next grant o_k_address = 0, o_grant = 8'h01.
REQ-030 Timeout: TIMEOUT = 4, i_request = 8'h08, i_done = 0 -> o_k_address = 3, o_valid high exactly 4 cycles, o_timeout = 1 single cycle as o_valid falls.
REQ-031 Precedence: TIMEOUT = 4, i_done = 1 in fourth grant cycle -> o_valid falls, o_timeout stays 0.
REQ-032 Async reset: assert i_rst_n low mid-grant between edges -> o_valid, o_grant drop to 0 immediately; next grant after release starts search at row 0.

Source files
------------

// File: rtl/arbiter_encoder.sv
// Round-robin arbiter for eight row requesters that drives a 3-bit row-select
// decoder address/valid pair, with a bounded hold time per grant.
module arbiter_encoder #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_request,
  input  logic       i_done,
  output logic [2:0] o_k_address,
  output logic       o_valid,
  output logic [7:0] o_grant,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] timer;
  logic [2:0] pick;
  logic [2:0] idx;
  logic       any_req;

  // Walk the offsets from farthest to nearest so the closest set bit at or
  // after ptr is the one that survives.
  always_comb begin
    pick    = ptr;
    idx     = ptr;
    any_req = |i_request;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (i_request[idx]) begin
        pick = idx;
      end
    end
  end

  // RELEASE shares the arbitration path with IDLE; it exists only to force a
  // one-cycle gap with o_valid low between consecutive grants.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      timer       <= 8'd0;
      o_k_address <= 3'd0;
      o_valid     <= 1'b0;
      o_grant     <= 8'h00;
      o_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          o_timeout <= 1'b0;
          if (any_req) begin
            state       <= GRANT;
            o_k_address <= pick;
            o_valid     <= 1'b1;
            o_grant     <= 8'b1 << pick;
            timer       <= 8'd0;
          end else begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_grant <= 8'h00;
          end
        end
        GRANT: begin
          if (i_done || (timer == TIMER_LAST)) begin
            state     <= RELEASE;
            o_valid   <= 1'b0;
            o_grant   <= 8'h00;
            ptr       <= o_k_address + 3'd1;
            o_timeout <= ~i_done;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          o_valid   <= 1'b0;
          o_grant   <= 8'h00;
          o_timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule
